// File: rtl/smc_window_buffer.sv
// Ping-pong window buffer: packs the SMC float stream into DEPTH-word windows and streams each one out oldest first.
// Latency: first word of a window is presented one cycle after the edge that stores its last sample.
// Backpressure: outputs hold while drdy_i=0; a sample arriving when both banks are full is dropped and flagged.
module smc_window_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          GlobalReset,
    input  logic [31:0]   x_i,
    input  logic          srdyi_i,
    input  logic          drdy_i,
    output logic [31:0]   y_o,
    output logic          srdyo_o,
    output logic [AW-1:0] idx_o,
    output logic          last_o,
    output logic          bank_o,
    output logic          overflow_o
);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bank_st_e;
    typedef enum logic {D_IDLE, D_SEND} drain_st_e;

    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

    // Window storage, addressed as {bank, index}.
    logic [31:0]   mem [0:2*DEPTH-1];

    bank_st_e      st_q   [0:1];
    bank_st_e      st_nxt [0:1];
    logic          wr_bank_q, wr_bank_nxt;
    logic [AW-1:0] wr_ptr_q, wr_ptr_nxt;
    logic          wr_en;
    logic [31:0]   wr_dat;
    logic          ovf_set;

    drain_st_e     d_q, d_nxt;
    logic          xfer;
    logic          release_bank;
    logic          ld;
    logic          ld_bank;
    logic [AW-1:0] ld_idx;
    logic [AW-1:0] idx_inc;
    logic          srdyo_nxt;
    logic [AW-1:0] idx_nxt;
    logic          last_nxt;
    logic          bank_nxt;
    logic [31:0]   y_nxt;

    assign xfer         = srdyo_o & drdy_i;
    assign release_bank = (d_q == D_SEND) & xfer & last_o;
    assign idx_inc      = idx_o + AW'(1);
    // Negative zero is folded to positive zero so downstream sees one zero encoding.
    assign wr_dat       = (x_i == 32'h8000_0000) ? 32'h0000_0000 : x_i;

    // Bank bookkeeping: a bank freed by the drain this cycle is treated as EMPTY before the write checks for overflow.
    always_comb begin
        st_nxt[0]   = st_q[0];
        st_nxt[1]   = st_q[1];
        wr_bank_nxt = wr_bank_q;
        wr_ptr_nxt  = wr_ptr_q;
        wr_en       = 1'b0;
        ovf_set     = 1'b0;
        if (release_bank) begin
            st_nxt[bank_o] = B_EMPTY;
        end
        if (srdyi_i) begin
            if (st_nxt[wr_bank_q] == B_FULL) begin
                ovf_set = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (wr_ptr_q == IDX_LAST) begin
                    st_nxt[wr_bank_q] = B_FULL;
                    wr_ptr_nxt        = '0;
                    wr_bank_nxt       = ~wr_bank_q;
                end else begin
                    st_nxt[wr_bank_q] = B_FILLING;
                    wr_ptr_nxt        = wr_ptr_q + AW'(1);
                end
            end
        end
    end

    // Write-side state registers and sticky overflow.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            st_q[0]    <= B_EMPTY;
            st_q[1]    <= B_EMPTY;
            wr_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            overflow_o <= 1'b0;
        end else begin
            st_q[0]    <= st_nxt[0];
            st_q[1]    <= st_nxt[1];
            wr_bank_q  <= wr_bank_nxt;
            wr_ptr_q   <= wr_ptr_nxt;
            overflow_o <= overflow_o | ovf_set;
        end
    end

    // Sample storage; contents are don't-care after reset because bank state gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_q, wr_ptr_q}] <= wr_dat;
        end
    end

    // Drain FSM next state and next output word; a bank completing this cycle chains in without a bubble.
    always_comb begin
        d_nxt     = d_q;
        srdyo_nxt = srdyo_o;
        idx_nxt   = idx_o;
        last_nxt  = last_o;
        bank_nxt  = bank_o;
        ld        = 1'b0;
        ld_bank   = bank_o;
        ld_idx    = '0;
        case (d_q)
            D_IDLE: begin
                if (st_q[0] == B_FULL || st_q[1] == B_FULL) begin
                    ld        = 1'b1;
                    ld_bank   = (st_q[0] == B_FULL) ? 1'b0 : 1'b1;
                    ld_idx    = '0;
                    bank_nxt  = ld_bank;
                    idx_nxt   = '0;
                    last_nxt  = 1'b0;
                    srdyo_nxt = 1'b1;
                    d_nxt     = D_SEND;
                end
            end
            D_SEND: begin
                if (xfer) begin
                    if (!last_o) begin
                        ld       = 1'b1;
                        ld_bank  = bank_o;
                        ld_idx   = idx_inc;
                        idx_nxt  = idx_inc;
                        last_nxt = (idx_inc == IDX_LAST);
                    end else if (st_nxt[~bank_o] == B_FULL) begin
                        ld       = 1'b1;
                        ld_bank  = ~bank_o;
                        ld_idx   = '0;
                        bank_nxt = ~bank_o;
                        idx_nxt  = '0;
                        last_nxt = 1'b0;
                    end else begin
                        srdyo_nxt = 1'b0;
                        idx_nxt   = '0;
                        last_nxt  = 1'b0;
                        d_nxt     = D_IDLE;
                    end
                end
            end
            default: begin
                d_nxt = D_IDLE;
            end
        endcase
        y_nxt = ld ? mem[{ld_bank, ld_idx}] : y_o;
    end

    // Drain state and registered output stage.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            d_q     <= D_IDLE;
            y_o     <= '0;
            srdyo_o <= 1'b0;
            idx_o   <= '0;
            last_o  <= 1'b0;
            bank_o  <= 1'b0;
        end else begin
            d_q     <= d_nxt;
            y_o     <= y_nxt;
            srdyo_o <= srdyo_nxt;
            idx_o   <= idx_nxt;
            last_o  <= last_nxt;
            bank_o  <= bank_nxt;
        end
    end

endmodule

// File: tb/tb_smc_window_buffer.sv
// Scoreboard bench for smc_window_buffer: expected words queued at stimulus time, popped on each output transfer.
// Latency: checks first-word timing, back-to-back ping-pong and stall hold directly.
// Backpressure: drives drdy_i low to force overflow and stall-hold checks.
module tb_smc_window_buffer;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef struct {
        logic [31:0]   dat;
        logic [AW-1:0] idx;
        logic          bnk;
    } sb_t;

    logic          clk;
    logic          GlobalReset;
    logic [31:0]   x_i;
    logic          srdyi_i;
    logic          drdy_i;
    logic [31:0]   y_o;
    logic          srdyo_o;
    logic [AW-1:0] idx_o;
    logic          last_o;
    logic          bank_o;
    logic          overflow_o;

    sb_t sb_q[$];
    int  n_chk;
    int  n_err;
    int  exp_cnt;
    int  cyc;
    int  xfer_cnt;
    int  first_cyc;
    int  last_cyc;

    smc_window_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .GlobalReset(GlobalReset),
        .x_i        (x_i),
        .srdyi_i    (srdyi_i),
        .drdy_i     (drdy_i),
        .y_o        (y_o),
        .srdyo_o    (srdyo_o),
        .idx_o      (idx_o),
        .last_o     (last_o),
        .bank_o     (bank_o),
        .overflow_o (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk_val({tag, "_y"},     y_o,        32'h0);
        chk_val({tag, "_srdyo"}, srdyo_o,    32'h0);
        chk_val({tag, "_idx"},   idx_o,      32'h0);
        chk_val({tag, "_last"},  last_o,     32'h0);
        chk_val({tag, "_bank"},  bank_o,     32'h0);
        chk_val({tag, "_ovf"},   overflow_o, 32'h0);
    endtask

    // Call at posedge+1; returns at the next posedge+1.
    task automatic send(input logic [31:0] d, input bit drop);
        sb_t e;
        if (!drop) begin
            e.dat = (d == 32'h8000_0000) ? 32'h0 : d;
            e.idx = AW'(exp_cnt % DEPTH);
            e.bnk = 1'((exp_cnt / DEPTH) % 2);
            sb_q.push_back(e);
            exp_cnt++;
        end
        x_i     = d;
        srdyi_i = 1'b1;
        @(posedge clk);
        #1;
        srdyi_i = 1'b0;
        x_i     = 32'h0;
    endtask

    task automatic do_reset(input bit check);
        @(posedge clk);
        #3;
        GlobalReset = 1'b0;
        #1;
        if (check) chk_zero_outputs("rst_mid");
        sb_q.delete();
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        GlobalReset = 1'b1;
    endtask

    task automatic wait_srdyo(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (srdyo_o) break;
            @(posedge clk);
            #1;
        end
        chk_val(tag, srdyo_o, 32'h1);
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk_val(tag, 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        n_chk = 0; n_err = 0; exp_cnt = 0; cyc = 0;
        xfer_cnt = 0; first_cyc = 0; last_cyc = 0;
        GlobalReset = 1'b0;
        x_i = 32'h0; srdyi_i = 1'b0; drdy_i = 1'b1;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                if (GlobalReset && srdyo_o && drdy_i) begin
                    if (sb_q.size() == 0) begin
                        chk_val("sb_underflow", 32'(sb_q.size()), 32'h1);
                    end else begin
                        sb_t e;
                        e = sb_q.pop_front();
                        chk_val("out_y",    y_o,    e.dat);
                        chk_val("out_idx",  idx_o,  e.idx);
                        chk_val("out_bank", bank_o, e.bnk);
                        chk_val("out_last", last_o, (e.idx == AW'(DEPTH - 1)));
                        if (xfer_cnt == 0) first_cyc = cyc;
                        last_cyc = cyc;
                        xfer_cnt++;
                    end
                end
            end
        join_none

        // Power-on reset state.
        #1;
        chk_zero_outputs("rst_init");
        repeat (2) @(posedge clk);
        #1;
        GlobalReset = 1'b1;

        // Basic window, spaced strobes, first-word latency.
        drdy_i = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            send(32'h3F80_0000 + 32'(k), 1'b0);
            if (k == DEPTH - 1) begin
                chk_val("t2_srdyo_at_t", srdyo_o, 32'h0);
                @(posedge clk);
                #1;
                chk_val("t2_srdyo_at_t1", srdyo_o, 32'h1);
            end else begin
                repeat (17) @(posedge clk);
                #1;
            end
        end
        wait_empty("t2_drained");

        // Ping-pong back-to-back.
        do_reset(1'b1);
        xfer_cnt = 0;
        for (int k = 0; k < 2 * DEPTH; k++) send(32'h1000_0000 + 32'(k), 1'b0);
        wait_empty("t3_drained");
        chk_val("t3_xfers", 32'(xfer_cnt), 32'd16);
        chk_val("t3_no_gap", 32'(last_cyc - first_cyc), 32'd15);
        chk_val("t3_ovf", overflow_o, 32'h0);

        // Backpressure and overflow.
        do_reset(1'b0);
        drdy_i = 1'b0;
        for (int k = 0; k < 2 * DEPTH + 1; k++) send(32'h4000_0000 + 32'(k), (k == 2 * DEPTH));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_val("t4_srdyo_held", srdyo_o,    32'h1);
        chk_val("t4_y_word0",    y_o,        32'h4000_0000);
        chk_val("t4_idx0",       idx_o,      32'h0);
        chk_val("t4_bank0",      bank_o,     32'h0);
        chk_val("t4_ovf",        overflow_o, 32'h1);
        @(posedge clk);
        #1;
        xfer_cnt = 0;
        drdy_i   = 1'b1;
        wait_empty("t4_drained");
        chk_val("t4_xfers", 32'(xfer_cnt), 32'd16);

        // Negative zero and stall stability.
        drdy_i = 1'b0;
        send(32'h8000_0000, 1'b0);
        send(32'h8000_0001, 1'b0);
        for (int k = 2; k < DEPTH; k++) send(32'h5000_0000 + 32'(k), 1'b0);
        wait_srdyo("t5_srdyo");
        drdy_i = 1'b1;
        @(posedge clk);
        #1;
        drdy_i = 1'b0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk_val("t5_stall_y",   y_o,   sb_q[0].dat);
            chk_val("t5_stall_idx", idx_o, 32'(sb_q[0].idx));
            @(posedge clk);
            #1;
        end
        drdy_i = 1'b1;
        wait_empty("t5_drained");
        chk_val("t5_ovf_sticky", overflow_o, 32'h1);

        // Reset mid-drain, then a fresh window.
        for (int k = 0; k < DEPTH; k++) send(32'h6000_0000 + 32'(k), 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (idx_o == 3) break;
        end
        chk_val("t6_reach_idx3", idx_o, 32'd3);
        #2;
        GlobalReset = 1'b0;
        #1;
        chk_zero_outputs("t6_rst");
        sb_q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        GlobalReset = 1'b1;
        xfer_cnt = 0;
        for (int k = 0; k < DEPTH - 1; k++) send(32'h7000_0000 + 32'(k), 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk_val("t6_no_early_srdyo", srdyo_o, 32'h0);
        send(32'h7000_0007, 1'b0);
        wait_empty("t6_drained");
        chk_val("t6_xfers", 32'(xfer_cnt), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/smc_window_buffer.md
Name: smc_window_buffer

Overview:
- Consumes the 32-bit SMC float stream produced by the centre/scale stage: one sample per `srdyi_i` pulse.
- Groups samples into windows of DEPTH words using two ping-pong banks.
- Streams each completed window, oldest sample first, to the downstream feature/classifier stage over a valid/ready handshake.
- Filling one bank and draining the other overlap, so no sample is lost while the downstream stage keeps pace.

Parameters:
- DEPTH, 8, samples per window; power of two, 2..64.
- AW, 3, index width; must equal log2(DEPTH).

Ports:
- `clk` input 1: single clock, rising edge.
- `GlobalReset` input 1: asynchronous, active-low reset.
- `x_i` input 32: SMC float sample, i.e. the centre/scale stage output.
- `srdyi_i` input 1: one-cycle strobe; `x_i` is valid this cycle.
- `drdy_i` input 1: downstream ready.
- `y_o` output 32: window sample out, registered.
- `srdyo_o` output 1: `y_o` valid, registered.
- `idx_o` output AW: position of `y_o` within its window; 0 = oldest.
- `last_o` output 1: high with the final word of a window (`idx_o` = DEPTH-1).
- `bank_o` output 1: bank currently being drained.
- `overflow_o` output 1: sticky; a sample was dropped.

Behaviour:
- **Reset:** while `GlobalReset`=0, asynchronously clear:
  - outputs: `y_o`=0, `srdyo_o`=0, `idx_o`=0, `last_o`=0, `bank_o`=0, `overflow_o`=0;
  - internal state: both banks EMPTY, write bank=0, write pointer=0, read pointer=0.
  - Bank contents need not reset.
  - Reset mid-window discards all partial and full windows.
- **Bank states:** each bank is EMPTY, FILLING or FULL. Only one bank is FILLING or the target of writes at a time.
- **Write path, on `srdyi_i`=1:**
  - If the write bank is EMPTY or FILLING: store `x_i` at [write pointer] and mark the bank FILLING.
  - Canonicalise negative zero: 0x80000000 is stored as 0x00000000. All other values are stored unchanged.
  - When the write pointer reaches DEPTH-1: mark the bank FULL, wrap the pointer to 0, and toggle the write bank.
  - If the write bank is FULL (both banks full): drop the sample, set `overflow_o`=1 (cleared only by reset), and leave the pointer unchanged.
- **Drain FSM, states IDLE, SEND:**
  - **IDLE:** if any bank is FULL, select it (the lower-numbered bank if both are FULL, which only follows reset ordering), load word 0 into `y_o`, set `idx_o`=0, `srdyo_o`=1, drive `bank_o`, and go to SEND.
  - **Latency:** the edge that writes the DEPTH-th sample is edge t; `srdyo_o` rises at edge t+1.
  - **SEND:** `y_o`, `idx_o`, `last_o` and `bank_o` are held stable while `srdyo_o`=1 and `drdy_i`=0.
  - On `srdyo_o`=1 with `drdy_i`=1 and `idx_o` < DEPTH-1: present the next word at the next edge, giving one word per cycle at full throughput.
  - On the transfer of `last_o`:
    - mark the drained bank EMPTY;
    - if the other bank is already FULL, load its word 0 at the next edge with no bubble;
    - otherwise set `srdyo_o`=0 and return to IDLE.
- **Simultaneous events:**
  - A write into bank B and a drain of bank A in the same cycle are independent.
  - A write that completes bank B in the same cycle that A's last word transfers makes B drain next cycle.
  - A sample arriving on the cycle A becomes EMPTY and is also the write bank is accepted, because the EMPTY update takes precedence over the overflow check.
- **Ordering:** words are emitted in arrival order and windows in completion order. Dropped samples never appear on `y_o`.
- **Storage:** registers or flops, 2×DEPTH×32. No combinational path exists from `x_i` or `srdyi_i` to the outputs.

Test Plan:
1. **Reset:** assert `GlobalReset`=0 asynchronously mid-cycle → all outputs go to 0 immediately. After release, the first `srdyo_o` appears only after 8 fresh strobes.
2. **Basic window:** DEPTH=8, `drdy_i`=1, 8 strobes of 0x3F800000+k (k=0..7) spaced 18 cycles apart. `srdyo_o` rises exactly one cycle after the 8th write, then `y_o` = 0x3F800000..0x3F800007 on 8 consecutive cycles, `idx_o` 0..7, `last_o` on the 8th word, `bank_o`=0.
3. **Ping-pong back-to-back:** 16 strobes on consecutive cycles with `drdy_i`=1 → bank 0 drains while bank 1 fills. 16 words are out in order, bank 1's word 0 follows bank 0's last word with no gap, and `overflow_o` stays 0.
4. **Backpressure and overflow:** `drdy_i`=0, 17 strobes → `y_o` holds word 0 of bank 0 and `srdyo_o` stays 1. The 17th sample is dropped and `overflow_o`=1. Raising `drdy_i` drains exactly 16 words, bank 0 then bank 1.
5. **Negative zero and stall stability:** sample 0x80000000 is emitted as 0x00000000, while 0x80000001 passes unchanged. `drdy_i` toggling 1,0,0,1 mid-window holds `y_o` and `idx_o` constant during the low cycles.
6. **Reset mid-drain:** reset at `idx_o`=3 → outputs clear. The next window contains only post-reset samples and `bank_o` restarts at 0.
